// File: rtl/ai_sample_avg_if.sv
// Bus between the AI-channel sample averager and its SPI controller / data-path neighbours.
// Optional range_err member exists only when AI_AVG_RANGE_CHK_EN is defined.
interface ai_sample_avg_if;
  // Handshake: rd_en is a 1-cycle request issued only while spi_busy=0; the controller
  // answers with a 1-cycle rd_dval carrying rd_data. avg_dval and smp_err are 1-cycle
  // strobes with no back-pressure; avg_data (and range_err) hold between strobes.
  logic        con_done;
  logic        spi_busy;
  logic        rd_dval;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        avg_dval;
  logic [15:0] avg_data;
  logic        smp_err;
  logic [7:0]  ovr_cnt;
`ifdef AI_AVG_RANGE_CHK_EN
  logic        range_err;

  modport master (
    output con_done, spi_busy, rd_dval, rd_data,
    input  rd_en, avg_dval, avg_data, smp_err, ovr_cnt, range_err
  );
  modport slave (
    input  con_done, spi_busy, rd_dval, rd_data,
    output rd_en, avg_dval, avg_data, smp_err, ovr_cnt, range_err
  );
`else
  modport master (
    output con_done, spi_busy, rd_dval, rd_data,
    input  rd_en, avg_dval, avg_data, smp_err, ovr_cnt
  );
  modport slave (
    input  con_done, spi_busy, rd_dval, rd_data,
    output rd_en, avg_dval, avg_data, smp_err, ovr_cnt
  );
`endif
endinterface

// File: rtl/ai_sample_avg.sv
// Burst-averaging consumer of the ADS8689 AI channel: 2^AVG_SHIFT reads per period tick.
// Define AI_AVG_RANGE_CHK_EN to add LO_LIM/HI_LIM and the range_err flag.
module ai_sample_avg #(
  parameter int unsigned AVG_SHIFT   = 3,
  parameter logic [15:0] PERIOD_CNT  = 16'd10000,
  parameter logic [11:0] TIMEOUT_CNT = 12'd2000
`ifdef AI_AVG_RANGE_CHK_EN
  ,
  parameter logic [15:0] LO_LIM      = 16'h0400,
  parameter logic [15:0] HI_LIM      = 16'hFC00
`endif
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  ai_sample_avg_if.slave bus,
  output logic [2:0]   dbg_state
);

  localparam int ACC_W = 16 + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << AVG_SHIFT) - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    REQ       = 3'd2,
    WAIT_DATA = 3'd3,
    ACC       = 3'd4,
    OUT       = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        per_cnt_q, per_cnt_d;
  logic [11:0]        to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        cap_q, cap_d;
  logic [15:0]        avg_data_q, avg_data_d;
  logic               avg_dval_q, avg_dval_d;
  logic [7:0]         ovr_cnt_q, ovr_cnt_d;
  logic               tick;
  logic               rd_en;
  logic               smp_err;
  logic [15:0]        avg_new;
`ifdef AI_AVG_RANGE_CHK_EN
  logic               range_err_q, range_err_d;
`endif

  assign avg_new = acc_q[ACC_W-1:AVG_SHIFT];

  always_comb begin
    per_cnt_d  = per_cnt_q;
    tick       = 1'b0;
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    acc_d      = acc_q;
    cap_d      = cap_q;
    avg_data_d = avg_data_q;
    avg_dval_d = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;
    rd_en      = 1'b0;
    smp_err    = 1'b0;
`ifdef AI_AVG_RANGE_CHK_EN
    range_err_d = range_err_q;
`endif

    if (!bus.con_done) begin
      per_cnt_d = 16'd0;
    end else if (per_cnt_q == PERIOD_CNT - 16'd1) begin
      per_cnt_d = 16'd0;
      tick      = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + 16'd1;
    end

    // A tick that arrives while a burst is still running is counted and otherwise dropped.
    if (tick && (state_q != WAIT_TICK) && (state_q != IDLE) && (ovr_cnt_q != 8'hFF))
      ovr_cnt_d = ovr_cnt_q + 8'd1;

    if (!bus.con_done) begin
      state_d   = IDLE;
      acc_d     = '0;
      smp_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_TICK;
        WAIT_TICK: begin
          if (tick) begin
            acc_d     = '0;
            smp_cnt_d = '0;
            state_d   = REQ;
          end
        end
        REQ: begin
          if (!bus.spi_busy) begin
            rd_en    = 1'b1;
            to_cnt_d = 12'd0;
            state_d  = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // rd_dval takes priority over a timeout expiring in the same cycle.
          if (bus.rd_dval) begin
            cap_d   = bus.rd_data;
            state_d = ACC;
          end else if (to_cnt_q == TIMEOUT_CNT - 12'd1) begin
            smp_err = 1'b1;
            state_d = WAIT_TICK;
          end else begin
            to_cnt_d = to_cnt_q + 12'd1;
          end
        end
        ACC: begin
          acc_d     = acc_q + ACC_W'(cap_q);
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          state_d   = (smp_cnt_q == LAST_SMP) ? OUT : REQ;
        end
        OUT: begin
          avg_data_d = avg_new;
          avg_dval_d = 1'b1;
`ifdef AI_AVG_RANGE_CHK_EN
          range_err_d = (avg_new < LO_LIM) || (avg_new > HI_LIM);
`endif
          state_d    = WAIT_TICK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q    <= IDLE;
      per_cnt_q  <= 16'd0;
      to_cnt_q   <= 12'd0;
      smp_cnt_q  <= '0;
      acc_q      <= '0;
      cap_q      <= 16'd0;
      avg_data_q <= 16'h0000;
      avg_dval_q <= 1'b0;
      ovr_cnt_q  <= 8'd0;
`ifdef AI_AVG_RANGE_CHK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      acc_q      <= acc_d;
      cap_q      <= cap_d;
      avg_data_q <= avg_data_d;
      avg_dval_q <= avg_dval_d;
      ovr_cnt_q  <= ovr_cnt_d;
`ifdef AI_AVG_RANGE_CHK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  assign bus.rd_en    = rd_en;
  assign bus.smp_err  = smp_err;
  assign bus.avg_dval = avg_dval_q;
  assign bus.avg_data = avg_data_q;
  assign bus.ovr_cnt  = ovr_cnt_q;
`ifdef AI_AVG_RANGE_CHK_EN
  assign bus.range_err = range_err_q;
`endif
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ai_sample_avg.sv
// Directed bench for ai_sample_avg: AVG_SHIFT=3, PERIOD_CNT=200, TIMEOUT_CNT=50,
// with a behavioural ADC answering each rd_en after a programmable latency.
module tb_ai_sample_avg;

  logic       clk_sys;
  logic       rst_sys;
  logic [2:0] dbg_state;
  int         cyc;

  ai_sample_avg_if bus ();

  ai_sample_avg #(
    .AVG_SHIFT   (3),
    .PERIOD_CNT  (16'd200),
    .TIMEOUT_CNT (12'd50)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int rd_n = 0, avg_n = 0, err_n = 0;
  int rd_cyc = 0, err_cyc = 0;

  // ADC model controls
  int          adc_lat  = 20;
  int          adc_mode = 0;
  logic [15:0] adc_code = 16'h0000;
  int          drop_idx = -1;
  int          rd_cnt   = 0;
  int          idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_avg(input string tag, input int budget);
    int n0;
    int k;
    n0 = avg_n;
    k  = 0;
    while (avg_n == n0 && k < budget) begin
      step();
      k++;
    end
    if (avg_n == n0) fail_timeout(tag);
  endtask

  // ---------------- ADC model ----------------
  initial begin
    bus.rd_dval = 1'b0;
    bus.rd_data = 16'h0000;
    forever begin
      @(negedge clk_sys);
      bus.rd_dval = 1'b0;
      if (bus.rd_en) begin
        idx = rd_cnt;
        rd_cnt++;
        if (idx != drop_idx) begin
          repeat (adc_lat) @(negedge clk_sys);
          bus.rd_data = (adc_mode == 1) ? 16'(idx % 8) : adc_code;
          bus.rd_dval = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk_sys);
      if (bus.rd_en === 1'b1) begin
        rd_n++;
        rd_cyc = cyc;
      end
      if (bus.smp_err === 1'b1) begin
        err_n++;
        err_cyc = cyc;
      end
      if (bus.avg_dval === 1'b1) begin
        avg_n++;
        if (exp_q.size() == 0) begin
          fail_timeout("avg_unexpected");
        end else begin
          check("avg_data", 32'(bus.avg_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  int rd_base, avg_base, err_base;
  int k;

  initial begin
    rst_sys      = 1'b1;
    bus.con_done = 1'b0;
    bus.spi_busy = 1'b0;
    steps(3);
    check("rst_rd_en",    32'(bus.rd_en),    32'd0);
    check("rst_avg_dval", 32'(bus.avg_dval), 32'd0);
    check("rst_avg_data", 32'(bus.avg_data), 32'h0000);
    check("rst_smp_err",  32'(bus.smp_err),  32'd0);
    check("rst_ovr_cnt",  32'(bus.ovr_cnt),  32'd0);
    rst_sys = 1'b0;

    // Constant code 0x1000
    while (cyc < 10) step();
    adc_mode = 0; adc_code = 16'h1000; rd_cnt = 0;
    rd_base = rd_n;
    exp_q.push_back(16'h1000);
    bus.con_done = 1'b1;
    wait_avg("avg_1000", 700);
    check("rd_en_count_1", 32'(rd_n - rd_base), 32'd8);
    check("smp_err_none",  32'(err_n),          32'd0);
    check("ovr_zero_1",    32'(bus.ovr_cnt),    32'd0);
`ifdef AI_AVG_RANGE_CHK_EN
    check("range_1000", 32'(bus.range_err), 32'd0);
`endif

    // Ramp 0..7 -> 28>>3 = 3
    adc_mode = 1; rd_cnt = 0;
    rd_base = rd_n;
    exp_q.push_back(16'h0003);
    wait_avg("avg_ramp", 400);
    check("rd_en_count_2", 32'(rd_n - rd_base), 32'd8);
`ifdef AI_AVG_RANGE_CHK_EN
    check("range_0003", 32'(bus.range_err), 32'd1);
`endif

    // Full scale, accumulator must not overflow
    adc_mode = 0; adc_code = 16'hFFFF; rd_cnt = 0;
    exp_q.push_back(16'hFFFF);
    wait_avg("avg_ffff", 400);
`ifdef AI_AVG_RANGE_CHK_EN
    check("range_ffff", 32'(bus.range_err), 32'd1);
`endif

    // Third read withheld -> timeout 50 cycles after its rd_en
    adc_code = 16'h2222; rd_cnt = 0; drop_idx = 2;
    rd_base = rd_n; avg_base = avg_n; err_base = err_n;
    k = 0;
    while (err_n == err_base && k < 400) begin step(); k++; end
    if (err_n == err_base) fail_timeout("smp_err_wait");
    check("smp_err_delay",  32'(err_cyc - rd_cyc), 32'd50);
    check("rd_en_before_to", 32'(rd_n - rd_base),  32'd3);
    check("no_avg_on_to",   32'(avg_n - avg_base), 32'd0);
    check("avg_hold_to",    32'(bus.avg_data),     32'hFFFF);
    drop_idx = -1; rd_cnt = 0;
    exp_q.push_back(16'h2222);
    wait_avg("avg_after_to", 400);

    // Latency 30: each burst overruns the next tick
    adc_lat = 30; adc_code = 16'h4444;
    exp_q.push_back(16'h4444);
    wait_avg("avg_slow_1", 700);
    check("ovr_one", 32'(bus.ovr_cnt), 32'd1);
    exp_q.push_back(16'h4444);
    wait_avg("avg_slow_2", 700);
    check("ovr_two", 32'(bus.ovr_cnt), 32'd2);

    // con_done dropped after 4 samples
    adc_lat = 20; adc_code = 16'h1111;
    rd_base = rd_n;
    k = 0;
    while ((rd_n - rd_base) < 5 && k < 500) begin step(); k++; end
    if ((rd_n - rd_base) < 5) fail_timeout("rd_en_5_wait");
    bus.con_done = 1'b0;
    rd_base = rd_n; avg_base = avg_n; err_base = err_n;
    steps(100);
    check("abort_rd_en",    32'(rd_n - rd_base),   32'd0);
    check("abort_avg_dval", 32'(avg_n - avg_base), 32'd0);
    check("abort_smp_err",  32'(err_n - err_base), 32'd0);
    check("abort_avg_hold", 32'(bus.avg_data),     32'h4444);
    check("abort_state",    32'(dbg_state),        32'd0);
    adc_code = 16'h0800;
    exp_q.push_back(16'h0800);
    bus.con_done = 1'b1;
    wait_avg("avg_after_abort", 700);

    // Asynchronous reset in the middle of a burst
    rd_base = rd_n;
    k = 0;
    while ((rd_n - rd_base) < 2 && k < 400) begin step(); k++; end
    if ((rd_n - rd_base) < 2) fail_timeout("rd_en_2_wait");
    rst_sys = 1'b1;
    #1;
    check("mid_rst_avg_data", 32'(bus.avg_data), 32'h0000);
    check("mid_rst_ovr_cnt",  32'(bus.ovr_cnt),  32'd0);
    check("mid_rst_rd_en",    32'(bus.rd_en),    32'd0);
    check("mid_rst_avg_dval", 32'(bus.avg_dval), 32'd0);
    check("mid_rst_smp_err",  32'(bus.smp_err),  32'd0);
    check("mid_rst_state",    32'(dbg_state),    32'd0);
    steps(3);
    bus.spi_busy = 1'b1;
    rst_sys = 1'b0;

    // spi_busy held: burst stalls in REQ, every later tick is a miss
    rd_base = rd_n;
    k = 0;
    while (bus.ovr_cnt == 8'd0 && k < 700) begin step(); k++; end
    if (bus.ovr_cnt == 8'd0) fail_timeout("ovr_first_wait");
    check("ovr_first", 32'(bus.ovr_cnt), 32'd1);
    steps(1100);
    check("ovr_six",   32'(bus.ovr_cnt), 32'd6);
    steps(260 * 200);
    check("ovr_sat",   32'(bus.ovr_cnt), 32'hFF);
    check("busy_no_rd_en", 32'(rd_n - rd_base), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
